// File: rtl/config_pkg.sv
// Shared widths and the op bundle for the FP<->int conversion shift path.
package config_pkg;
  localparam int CVTLEN   = 64;
  localparam int NF       = 52;
  localparam int SHW      = CVTLEN + NF + 1;
  localparam int SAW      = $clog2(SHW);
  localparam int CVT_TAGW = 5;

  typedef struct packed {
    logic [SHW-1:0]      data;
    logic [SAW-1:0]      amt;
    logic                uf;
    logic [CVT_TAGW-1:0] tag;
  } cvt_shift_op_t;

  // Any amount at or beyond the data width shifts every bit out.
  function automatic logic amt_overshift(input logic [SAW-1:0] amt);
    return {1'b0, amt} >= (SAW+1)'(SHW);
  endfunction
endpackage

// File: rtl/cvt_barrel_lsh.sv
// Combinational logarithmic left shifter, result truncated to W bits.
// Latency 0; no handshake.
module cvt_barrel_lsh #(
  parameter int W  = 8,
  parameter int SA = 3
) (
  input  logic [W-1:0]  d,
  input  logic [SA-1:0] amt,
  output logic [W-1:0]  y
);
  always_comb begin
    y = d;
    for (int i = 0; i < SA; i++) begin
      if (amt[i]) y = y << (2**i);
    end
  end
endmodule

// File: rtl/cvt_norm_shift_pipe.sv
// Two-stage coarse/fine normalization shifter feeding the conversion rounder.
// Latency 2 cycles; InReady is combinational from OutReady (no skid), full pipe stalls upstream.
module cvt_norm_shift_pipe
  import config_pkg::*;
#(
  parameter int FINEBITS = 2,
  parameter int TAGW     = CVT_TAGW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [SHW-1:0]  CvtShiftIn,
  input  logic [SAW-1:0]  CvtShiftAmt,
  input  logic            CvtResUfIn,
  input  logic [TAGW-1:0] TagIn,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [SHW-1:0]  Shifted,
  output logic            CvtResUf,
  output logic [TAGW-1:0] TagOut,
  output logic            Overshift
);
  cvt_shift_op_t       op_in;
  logic                s1_vld, s2_vld;
  logic                adv1, adv2, acc;
  logic                ovs_in;
  logic [SAW-1:0]      coarse_amt;
  logic [SHW-1:0]      coarse, fine;
  logic [SHW-1:0]      s1_dat, s2_dat;
  logic [FINEBITS-1:0] s1_fine;
  logic                s1_ovs, s1_uf, s2_ovs, s2_uf;
  logic [TAGW-1:0]     s1_tag, s2_tag;

  assign op_in = '{data: CvtShiftIn, amt: CvtShiftAmt, uf: CvtResUfIn, tag: TagIn};

  assign adv2    = ~s2_vld | OutReady;
  assign adv1    = ~s1_vld | adv2;
  assign acc     = InValid & adv1;
  assign InReady = adv1;

  assign coarse_amt = {op_in.amt[SAW-1:FINEBITS], {FINEBITS{1'b0}}};
  assign ovs_in     = amt_overshift(op_in.amt);

  cvt_barrel_lsh #(.W(SHW), .SA(SAW)) u_coarse (
    .d   (op_in.data),
    .amt (coarse_amt),
    .y   (coarse)
  );

  cvt_barrel_lsh #(.W(SHW), .SA(FINEBITS)) u_fine (
    .d   (s1_dat),
    .amt (s1_fine),
    .y   (fine)
  );

  // Flush beats accept/advance; data regs are left alone and simply go stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else if (Flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (adv1) s1_vld <= InValid;
      if (adv2) s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_dat  <= '0;
      s1_fine <= '0;
      s1_ovs  <= 1'b0;
      s1_uf   <= 1'b0;
      s1_tag  <= '0;
    end else if (acc) begin
      s1_dat  <= ovs_in ? '0 : coarse;
      s1_fine <= op_in.amt[FINEBITS-1:0];
      s1_ovs  <= ovs_in;
      s1_uf   <= op_in.uf;
      s1_tag  <= op_in.tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_dat <= '0;
      s2_ovs <= 1'b0;
      s2_uf  <= 1'b0;
      s2_tag <= '0;
    end else if (adv2 & s1_vld) begin
      s2_dat <= fine;
      s2_ovs <= s1_ovs;
      s2_uf  <= s1_uf;
      s2_tag <= s1_tag;
    end
  end

  assign OutValid  = s2_vld;
  assign Shifted   = s2_dat;
  assign CvtResUf  = s2_uf;
  assign TagOut    = s2_tag;
  assign Overshift = s2_ovs;
endmodule

// File: tb/tb_cvt_norm_shift_pipe.sv
// Bench for cvt_norm_shift_pipe: directed scenarios plus a randomized run against a << reference.
module tb_cvt_norm_shift_pipe;
  import config_pkg::*;

  typedef struct packed {
    logic [SHW-1:0] sh;
    logic           ovs;
    logic           uf;
    logic [4:0]     tag;
  } res_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           Flush;
  logic           InValid;
  logic           InReady;
  logic [SHW-1:0] CvtShiftIn;
  logic [SAW-1:0] CvtShiftAmt;
  logic           CvtResUfIn;
  logic [4:0]     TagIn;
  logic           OutValid;
  logic           OutReady;
  logic [SHW-1:0] Shifted;
  logic           CvtResUf;
  logic [4:0]     TagOut;
  logic           Overshift;

  int total = 0;
  int bad = 0;
  int orphan = 0;
  int cyc = 0;
  res_t inflight[$];
  res_t exp_q[$];
  res_t obs_q[$];
  int   obs_cyc[$];

  always #5 clk = ~clk;

  cvt_norm_shift_pipe dut (
    .clk(clk), .reset_n(reset_n), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .CvtShiftIn(CvtShiftIn), .CvtShiftAmt(CvtShiftAmt),
    .CvtResUfIn(CvtResUfIn), .TagIn(TagIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .Shifted(Shifted), .CvtResUf(CvtResUf),
    .TagOut(TagOut), .Overshift(Overshift)
  );

  function automatic res_t ref_op(input logic [SHW-1:0] d, input logic [SAW-1:0] a,
                                  input logic uf, input logic [4:0] t);
    res_t e;
    int unsigned n;
    n = a;
    e.ovs = (n >= SHW);
    e.sh  = '0;
    if (!e.ovs) e.sh = d << n;
    e.uf  = uf;
    e.tag = t;
    return e;
  endfunction

  function automatic logic [SHW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[SHW-1:0];
  endfunction

  task automatic set_idle();
    InValid = 1'b0; Flush = 1'b0;
    CvtShiftIn = '0; CvtShiftAmt = '0; CvtResUfIn = 1'b0; TagIn = '0;
  endtask

  task automatic drive_op(input logic [SHW-1:0] d, input logic [SAW-1:0] a,
                          input logic uf, input logic [4:0] t);
    InValid = 1'b1; CvtShiftIn = d; CvtShiftAmt = a; CvtResUfIn = uf; TagIn = t;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); orphan = 0;
  endtask

  // Records handshakes that happen at the coming posedge, then moves to the next negedge.
  task automatic tick();
    #1;
    if (OutValid && OutReady) begin
      if (inflight.size() == 0) orphan++;
      else begin
        obs_q.push_back({Shifted, Overshift, CvtResUf, TagOut});
        obs_cyc.push_back(cyc);
        exp_q.push_back(inflight.pop_front());
      end
    end
    if (Flush) inflight.delete();
    else if (InValid && InReady) inflight.push_back(ref_op(CvtShiftIn, CvtShiftAmt, CvtResUfIn, TagIn));
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; OutReady = 1'b0; set_idle();
    repeat (2) @(negedge clk);
    total++;
    if ({OutValid, Overshift, CvtResUf, TagOut} !== 8'h00) begin
      bad++; $display("FAIL reset_flags got=%h exp=00", {OutValid, Overshift, CvtResUf, TagOut});
    end
    total++;
    if (Shifted !== '0) begin bad++; $display("FAIL reset_shifted got=%h exp=0", Shifted); end
    reset_n = 1'b1;
    inflight.delete();
    for (int i = 0; i < 10; i++) begin
      #1;
      total++;
      if (InReady !== 1'b1) begin bad++; $display("FAIL idle_inready cyc%0d got=%b exp=1", i, InReady); end
      total++;
      if (OutValid !== 1'b0) begin bad++; $display("FAIL idle_outvalid cyc%0d got=%b exp=0", i, OutValid); end
      total++;
      if (Shifted !== '0) begin bad++; $display("FAIL idle_shifted cyc%0d got=%h exp=0", i, Shifted); end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    logic [SHW-1:0] one;
    logic [SHW-1:0] exp_sh;
    one = 1;
    exp_sh = one << (SHW-1);
    clear_sb(); OutReady = 1'b1;
    drive_op(one, SAW'(SHW-1), 1'b0, 5'h3);
    tick();
    set_idle();
    total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", OutValid); end
    tick();
    total++;
    if (OutValid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", OutValid); end
    total++;
    if (Shifted !== exp_sh) begin bad++; $display("FAIL single_data got=%h exp=%h", Shifted, exp_sh); end
    total++;
    if ({TagOut, Overshift} !== {5'h3, 1'b0}) begin
      bad++; $display("FAIL single_tag_ovs got=%h/%b exp=03/0", TagOut, Overshift);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int amts[5] = '{0, 1, 4, 7, SHW-1};
    logic [SHW-1:0] d0;
    clear_sb(); OutReady = 1'b1;
    d0 = rand_data();
    for (int i = 0; i < 5; i++) begin
      drive_op((i == 0) ? d0 : rand_data(), SAW'(amts[i]), i[0], 5'(i + 8));
      #1;
      total++;
      if (InReady !== 1'b1) begin bad++; $display("FAIL b2b_inready op%0d got=%b exp=1", i, InReady); end
      tick();
    end
    set_idle();
    repeat (4) tick();
    total++;
    if (obs_q.size() != 5 || orphan != 0) begin
      bad++; $display("FAIL b2b_count got=%0d orphan=%0d exp=5", obs_q.size(), orphan);
    end else begin
      total++;
      if (obs_q[0].sh !== d0) begin bad++; $display("FAIL b2b_amt0 got=%h exp=%h", obs_q[0].sh, d0); end
      for (int i = 0; i < 5; i++) begin
        total++;
        if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 5'(i + 8)) begin
          bad++; $display("FAIL b2b_res%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
        if (i > 0) begin
          total++;
          if (obs_cyc[i] - obs_cyc[i-1] != 1) begin
            bad++; $display("FAIL b2b_gap%0d got=%0d exp=1", i, obs_cyc[i] - obs_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [SHW-1:0] d[3];
    logic [SAW-1:0] a[3];
    res_t e1;
    clear_sb(); OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = rand_data(); a[i] = SAW'($urandom_range(0, SHW - 1));
    end
    e1 = ref_op(d[0], a[0], 1'b0, 5'd1);
    for (int i = 0; i < 2; i++) begin
      drive_op(d[i], a[i], 1'b0, 5'(i + 1));
      #1;
      total++;
      if (InReady !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%b exp=1", i, InReady); end
      tick();
    end
    drive_op(d[2], a[2], 1'b0, 5'd3);
    for (int s = 0; s < 2; s++) begin
      #1;
      total++;
      if (InReady !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%b exp=0", s, InReady); end
      total++;
      if ({OutValid, Shifted, TagOut} !== {1'b1, e1.sh, e1.tag}) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/%h/%h", s, OutValid, Shifted, TagOut, e1.sh, e1.tag);
      end
      tick();
    end
    OutReady = 1'b1;
    #1;
    total++;
    if (InReady !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", InReady); end
    tick();
    set_idle();
    repeat (5) tick();
    total++;
    if (obs_q.size() != 3 || orphan != 0) begin
      bad++; $display("FAIL bp_count got=%0d orphan=%0d exp=3", obs_q.size(), orphan);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_q[i] !== exp_q[i] || obs_q[i].tag !== 5'(i + 1)) begin
          bad++; $display("FAIL bp_res%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overshift();
    logic [SAW-1:0] amts[2];
    amts[0] = SAW'(SHW);
    amts[1] = '1;
    clear_sb(); OutReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_op(rand_data() | 1, amts[i], 1'b1, 5'(20 + i));
      tick();
      set_idle();
      tick();
      total++;
      if ({OutValid, Overshift, CvtResUf, TagOut} !== {1'b1, 1'b1, 1'b1, 5'(20 + i)}) begin
        bad++; $display("FAIL ovs_flags%0d got=%b%b%b/%h exp=111/%h", i, OutValid, Overshift, CvtResUf, TagOut, 5'(20 + i));
      end
      total++;
      if (Shifted !== '0) begin bad++; $display("FAIL ovs_data%0d got=%h exp=0", i, Shifted); end
      tick();
    end
  endtask

  task automatic test_flush();
    clear_sb(); OutReady = 1'b0;
    drive_op(rand_data(), SAW'(3), 1'b0, 5'd11); tick();
    drive_op(rand_data(), SAW'(5), 1'b0, 5'd12); tick();
    #1;
    total++;
    if (OutValid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", OutValid); end
    OutReady = 1'b1; Flush = 1'b1;
    drive_op(rand_data(), SAW'(9), 1'b0, 5'd13);
    tick();
    set_idle();
    #1;
    total++;
    if ({OutValid, InReady} !== 2'b01) begin
      bad++; $display("FAIL flush_post got=%b%b exp=01", OutValid, InReady);
    end
    drive_op(rand_data(), SAW'($urandom_range(0, SHW - 1)), 1'b1, 5'd14);
    tick();
    set_idle();
    repeat (4) tick();
    total++;
    if (obs_q.size() != 2 || orphan != 0) begin
      bad++; $display("FAIL flush_count got=%0d orphan=%0d exp=2", obs_q.size(), orphan);
    end else begin
      total++;
      if (obs_q[0].tag !== 5'd11 || obs_q[1].tag !== 5'd14 || obs_q[1] !== exp_q[1]) begin
        bad++; $display("FAIL flush_res got=%h exp=%h tags %h,%h", obs_q[1], exp_q[1], obs_q[0].tag, obs_q[1].tag);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_sb(); OutReady = 1'b0;
    drive_op(rand_data(), SAW'(2), 1'b1, 5'd21); tick();
    drive_op(rand_data(), SAW'(6), 1'b1, 5'd22); tick();
    set_idle();
    #1;
    total++;
    if (OutValid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", OutValid); end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({OutValid, InReady, Overshift, CvtResUf, TagOut} !== 9'b0_1000_0000) begin
      bad++; $display("FAIL arst_flags got=%b%b%b%b/%h exp=0100/00", OutValid, InReady, Overshift, CvtResUf, TagOut);
    end
    total++;
    if (Shifted !== '0) begin bad++; $display("FAIL arst_data got=%h exp=0", Shifted); end
    inflight.delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
    OutReady = 1'b1;
    #1;
    total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL arst_after got=%b exp=0", OutValid); end
    drive_op(rand_data(), SAW'($urandom_range(0, SHW - 1)), 1'b0, 5'd23);
    tick();
    set_idle();
    repeat (3) tick();
    total++;
    if (obs_q.size() != 1 || orphan != 0 || obs_q[0] !== exp_q[0] || obs_q[0].tag !== 5'd23) begin
      bad++; $display("FAIL arst_next got_n=%0d orphan=%0d exp_n=1", obs_q.size(), orphan);
    end
  endtask

  task automatic test_random();
    int  sent = 0;
    int  n = 10000;
    bit  hold = 0;
    logic exp_rdy;
    clear_sb(); inflight.delete();
    for (int c = 0; c < 60000 && sent < n; c++) begin
      Flush = ($urandom_range(0, 299) == 0);
      if (!hold && $urandom_range(0, 3) != 0) begin
        drive_op(rand_data(), SAW'($urandom_range(0, (1 << SAW) - 1)), 1'($urandom), 5'($urandom));
        hold = 1;
      end
      InValid = hold;
      OutReady = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (inflight.size() < 2) || OutReady;
      total++;
      if (InReady !== exp_rdy) begin
        bad++; $display("FAIL rnd_inready c%0d got=%b exp=%b", c, InReady, exp_rdy);
      end
      if (inflight.size() != 1) begin
        total++;
        if (OutValid !== (inflight.size() == 2)) begin
          bad++; $display("FAIL rnd_outvalid c%0d got=%b exp=%b", c, OutValid, inflight.size() == 2);
        end
      end
      if (hold && (InReady || Flush)) begin
        sent++;
        hold = 0;
      end
      tick();
    end
    total++;
    if (sent != n) begin bad++; $display("FAIL rnd_timeout got=%0d exp=%0d", sent, n); end
    set_idle(); OutReady = 1'b1;
    repeat (4) tick();
    total++;
    if (inflight.size() != 0 || orphan != 0 || obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rnd_drain got=%0d/%0d/%0d exp=0/0/%0d", inflight.size(), orphan, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rnd_res%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overshift();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
